// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port synchronous data memory between the processor
//   load/store path and a debug/loader port. At most one requester is granted
//   per cycle (combinationally), the memory port is driven from the winner,
//   the processor is stalled when it loses, and read data is returned to the
//   owning port one cycle after the grant.
//   The CPU wins contests by default; once the debug port has been denied
//   STARVE_LIMIT contested cycles it wins the next contest.
//
// Ports
//   clk, reset                         clock, async active-high reset
//   cpu_req/we/addr/wdata              processor access request
//   cpu_stall                          cpu_req && !cpu granted
//   cpu_rdata/cpu_rvalid               processor load return
//   dbg_req/we/addr/wdata              debug port access request
//   dbg_gnt                            debug access accepted this cycle
//   dbg_rdata/dbg_rvalid               debug read return
//   mem_en/we/addr/wdata               memory port drive
//   mem_rdata                          memory read data (cycle after read)
module dmem_port_arbiter #(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_BITS     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic [DBITS-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [DBITS-1:0] dbg_addr,
  input  logic [DBITS-1:0] dbg_wdata,
  output logic             dbg_gnt,
  output logic [DBITS-1:0] dbg_rdata,
  output logic             dbg_rvalid,
  output logic             mem_en,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RD_NONE,
    RD_CPU,
    RD_DBG
  } rd_owner_t;

  rd_owner_t           rd_owner;
  logic [CNT_BITS-1:0] starve_cnt;
  logic                cpu_gnt;
  logic                dbg_priority;

  // Grant and memory-port mux. Nothing is granted while reset is high.
  always_comb begin
    dbg_priority = (starve_cnt == CNT_BITS'(STARVE_LIMIT));
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
    if (!reset) begin
      if (dbg_req && (!cpu_req || dbg_priority))
        dbg_gnt = 1'b1;
      else if (cpu_req)
        cpu_gnt = 1'b1;
    end

    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Starvation counter and read-return owner. The owner register alone marks
  // a pending read, so a new grant can issue while the previous read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      rd_owner   <= RD_NONE;
    end else begin
      if (dbg_gnt)
        starve_cnt <= '0;
      else if (dbg_req && cpu_req && !dbg_priority)
        starve_cnt <= starve_cnt + 1'b1;

      if (cpu_gnt && !cpu_we)
        rd_owner <= RD_CPU;
      else if (dbg_gnt && !dbg_we)
        rd_owner <= RD_DBG;
      else
        rd_owner <= RD_NONE;
    end
  end

  // Read data is steered to the owner; the other port sees zeros.
  always_comb begin
    cpu_rvalid = (rd_owner == RD_CPU);
    dbg_rvalid = (rd_owner == RD_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DBITS(32), .STARVE_LIMIT(LIMIT), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory driven by the DUT's memory port.
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr[11:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr[11:2]];
  end

  // Reference model: its own memory image, a count of contested denials,
  // and the read expected to return this cycle (0 none, 1 cpu, 2 dbg).
  logic [31:0] model_mem [0:1023];
  int          m_streak = 0;
  int          m_pend = 0;
  logic [31:0] m_pend_data = '0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = '0;
      model_mem[i] = '0;
    end
  end

  function automatic int winner();
    if (reset) return 0;
    if (cpu_req && dbg_req) return (m_streak >= LIMIT) ? 2 : 1;
    if (cpu_req) return 1;
    if (dbg_req) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_streak = 0;
      m_pend = 0;
      m_pend_data = '0;
    end else begin
      int w;
      w = winner();
      m_pend = 0;
      if (w == 1) begin
        if (cpu_we) model_mem[cpu_addr[11:2]] = cpu_wdata;
        else begin m_pend = 1; m_pend_data = model_mem[cpu_addr[11:2]]; end
      end else if (w == 2) begin
        if (dbg_we) model_mem[dbg_addr[11:2]] = dbg_wdata;
        else begin m_pend = 2; m_pend_data = model_mem[dbg_addr[11:2]]; end
      end
      if (w == 2) m_streak = 0;
      else if (cpu_req && dbg_req && m_streak < LIMIT) m_streak++;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    int w;
    logic [31:0] e_we, e_addr, e_wdata;
    w = winner();
    e_we = '0; e_addr = '0; e_wdata = '0;
    if (w == 1) begin e_we = {31'b0, cpu_we}; e_addr = cpu_addr; e_wdata = cpu_wdata; end
    if (w == 2) begin e_we = {31'b0, dbg_we}; e_addr = dbg_addr; e_wdata = dbg_wdata; end
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && w != 1});
    chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, w == 2});
    chk("mem_en", {31'b0, mem_en}, {31'b0, w != 0});
    chk("mem_we", {31'b0, mem_we}, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_pend == 1});
    chk("cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pend_data : 32'h0);
    chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, m_pend == 2});
    chk("dbg_rdata", dbg_rdata, (m_pend == 2) ? m_pend_data : 32'h0);
  end

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic dpat [0:7];
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
    tick();
    reset = 1'b0;

    // 1: cpu store then load
    drive(1, 1, 32'h400, 32'h37, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("t1_store_stall", {31'b0, cpu_stall}, 32'h0);
    tick(); drive(1, 0, 32'h400, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("t1_load_stall", {31'b0, cpu_stall}, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("t1_rvalid", {31'b0, cpu_rvalid}, 32'h1);
    chk("t1_rdata", cpu_rdata, 32'h00000037);
    chk("t1_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);

    // 2: dbg write then read
    tick(); drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h404, 32'hE1);
    @(negedge clk); chk("t2_wr_gnt", {31'b0, dbg_gnt}, 32'h1);
    tick(); drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h404, 32'h0);
    @(negedge clk); chk("t2_rd_gnt", {31'b0, dbg_gnt}, 32'h1);
    tick(); idle();
    @(negedge clk); chk("t2_rdata", dbg_rdata, 32'h000000E1);

    // 3: continuous contest, dbg wins on cycle 4 only
    tick(); drive(1, 0, 32'h400, 32'h0, 1, 0, 32'h404, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_dbg_gnt", {31'b0, dbg_gnt}, (i == 4) ? 32'h1 : 32'h0);
      chk("t3_stall", {31'b0, cpu_stall}, (i == 4) ? 32'h1 : 32'h0);
      tick();
    end
    idle();

    // 4: alternating reads return in order
    tick(); drive(1, 0, 32'h400, 32'h0, 0, 0, 32'h0, 32'h0);
    tick(); drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h404, 32'h0);
    @(negedge clk);
    chk("t4_cpu_rdata", cpu_rdata, 32'h37);
    chk("t4_dbg_rvalid_early", {31'b0, dbg_rvalid}, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("t4_dbg_rdata", dbg_rdata, 32'hE1);
    chk("t4_cpu_rvalid_late", {31'b0, cpu_rvalid}, 32'h0);

    // 5: reset lands on a granted dbg read
    tick(); drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h404, 32'h0);
    @(negedge clk); chk("t5_gnt", {31'b0, dbg_gnt}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_gnt", {31'b0, dbg_gnt}, 32'h0);
    chk("t5_rst_mem_en", {31'b0, mem_en}, 32'h0);
    tick();
    chk("t5_no_rvalid", {31'b0, dbg_rvalid}, 32'h0);
    chk("t5_rdata0", dbg_rdata, 32'h0);
    reset = 1'b0;
    drive(1, 0, 32'h400, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); chk("t5_cpu_after", {31'b0, mem_en && !cpu_stall}, 32'h1);

    // 6: dbg_req drops while cpu busy; denial count holds
    dpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick(); drive(1, 0, 32'h400, 32'h0, dpat[i], 0, 32'h404, 32'h0);
      @(negedge clk);
      chk("t6_dbg_gnt", {31'b0, dbg_gnt}, (i == 6) ? 32'h1 : 32'h0);
    end
    tick(); idle();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
